hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order pipeline, sitting alongside decode and the ID/EX pipeline register. It tracks in-flight writers through a per-register scoreboard:
- fixed-latency loads in a latency pipe;
- variable-latency multiply/divide (MDU) ops by completion pulse.

From that state it drives `stall_if`, `stall_id` and `flush_ex` for RAW hazards, WAW hazards and MDU-full conditions. It also drives `flush_id`/`flush_ex` on an EX-stage redirect.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_load_tracker.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 156 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard slice.
// Holds register index type, load pipe slot and latency floor.
package hazard_pkg;

    localparam int NUM_REGS_MAX = 32;
    localparam int LOAD_LAT_MIN = 2;

    typedef logic [$clog2(NUM_REGS_MAX)-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
    } load_slot_t;

endpackage

// File: rtl/hazard_load_tracker.sv
// Fixed-latency load tracker: LOAD_LAT-1 stage shift pipe of {valid, rd}.
// Ports: clk, rst (sync, high), push/push_rd (load issue), busy (per reg).
module hazard_load_tracker
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  reg_idx_t            push_rd,
    output logic [NUM_REGS-1:0] busy
);

    localparam int STAGES = LOAD_LAT - 1;

    load_slot_t pipe_q [STAGES];
    load_slot_t pipe_d [STAGES];

    // The pipe never stalls: stage 0 takes the new load (or a bubble).
    always_comb begin
        pipe_d[0].valid = push;
        pipe_d[0].rd    = push ? push_rd : '0;
        for (int s = 1; s < STAGES; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (rst) pipe_q[s] <= '0;
            else     pipe_q[s] <= pipe_d[s];
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int s = 0; s < STAGES; s++) begin
                if (pipe_q[s].valid && pipe_q[s].rd == reg_idx_t'(r))
                    busy[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: load tracker + MDU scoreboard -> stall/flush controls.
// Ports: ID operands/class, MDU done pulse, EX redirect; outputs
// stall_if/stall_id/flush_id/flush_ex and mdu_pending. Defining
// HAZARD_PERF_EN adds perf_stall_cycles / perf_flush_cycles counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int LOAD_LAT  = 2,
    parameter int MDU_DEPTH = 2,
    localparam int RW = $clog2(NUM_REGS),
    localparam int CW = MDU_DEPTH + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [RW-1:0] id_rd,
    input  logic          id_rd_we,
    input  logic          id_is_load,
    input  logic          id_is_mdu,
    input  logic          mdu_done,
    input  logic [RW-1:0] mdu_done_rd,
    input  logic          ex_redirect,
    output logic          stall_if,
    output logic          stall_id,
    output logic          flush_ex,
    output logic          flush_id,
    output logic [CW-1:0] mdu_pending
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   perf_stall_cycles,
    output logic [31:0]   perf_flush_cycles
`endif
);

    if (LOAD_LAT < LOAD_LAT_MIN) begin : g_lat_chk
        $error("LOAD_LAT below LOAD_LAT_MIN");
    end
    if (MDU_DEPTH < 1 || MDU_DEPTH > 4) begin : g_mdu_chk
        $error("MDU_DEPTH out of range 1..4");
    end
    if (NUM_REGS > NUM_REGS_MAX) begin : g_reg_chk
        $error("NUM_REGS exceeds reg_idx_t range");
    end

    logic [NUM_REGS-1:0] ld_busy, busy;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CW-1:0]       mdu_cnt_q, mdu_cnt_d;
    logic raw, waw, full, hz, issue;
    logic ld_push, mdu_inc, mdu_dec;

    hazard_load_tracker #(
        .NUM_REGS (NUM_REGS),
        .LOAD_LAT (LOAD_LAT)
    ) u_ld (
        .clk     (clk),
        .rst     (rst),
        .push    (ld_push),
        .push_rd (reg_idx_t'(id_rd)),
        .busy    (ld_busy)
    );

    // A completing MDU op is not busy: writeback forwards its value.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = ld_busy[r] ||
                (pend_q[r] && !(mdu_done && mdu_done_rd == RW'(r)));
        end
    end

    // cnt - done == DEPTH can only hold with no done this cycle.
    always_comb begin
        raw  = id_valid && ((id_rs1_used && busy[id_rs1]) ||
                            (id_rs2_used && busy[id_rs2]));
        waw  = id_valid && id_rd_we && id_rd != '0 && busy[id_rd];
        full = id_valid && id_is_mdu && !mdu_done &&
               mdu_cnt_q == CW'(MDU_DEPTH);
        hz    = raw || waw || full;
        issue = id_valid && !hz && !ex_redirect;
    end

    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_ex = 1'b0;
        flush_id = 1'b0;
        if (ex_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else begin
            stall_if = hz;
            stall_id = hz;
            flush_ex = hz;
        end
    end

    always_comb begin
        ld_push = issue && id_is_load && id_rd_we && id_rd != '0;
        mdu_inc = issue && id_is_mdu;
        // Spurious done with nothing outstanding is dropped.
        mdu_dec = mdu_done && mdu_cnt_q != '0;
        mdu_cnt_d = mdu_cnt_q + CW'(mdu_inc) - CW'(mdu_dec);
        pend_d = pend_q;
        if (mdu_done) pend_d[mdu_done_rd] = 1'b0;
        if (mdu_inc && id_rd != '0) pend_d[id_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            mdu_cnt_q <= '0;
        end else begin
            pend_q    <= pend_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mdu_done && mdu_cnt_q == '0))
            else $error("mdu_done with no outstanding MDU op");
        end
    end

    assign mdu_pending = mdu_cnt_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(stall_id);
        perf_flush_d = perf_flush_q + 32'(flush_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard (LOAD_LAT 2 and 4).
// Table of per-cycle vectors plus hand sequences for latency/reset.
module tb_hazard_scoreboard;

    localparam int K_IDLE = 0;
    localparam int K_ALU  = 1;
    localparam int K_LD   = 2;
    localparam int K_MDU  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we;
    logic       id_is_load, id_is_mdu;
    logic       mdu_done;
    logic [4:0] mdu_done_rd;
    logic       ex_redirect;

    logic       stall_if, stall_id, flush_ex, flush_id;
    logic [2:0] mdu_pending;
    logic       s4_if, s4_id, f4_ex, f4_id;
    logic [2:0] p4;
`ifdef HAZARD_PERF_EN
    logic [31:0] pst, pfl, pst4, pfl4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(2), .MDU_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd),
        .ex_redirect(ex_redirect),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_ex(flush_ex), .flush_id(flush_id),
        .mdu_pending(mdu_pending)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(pst), .perf_flush_cycles(pfl)
`endif
    );

    hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(4), .MDU_DEPTH(2)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd),
        .ex_redirect(ex_redirect),
        .stall_if(s4_if), .stall_id(s4_id),
        .flush_ex(f4_ex), .flush_id(f4_id),
        .mdu_pending(p4)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(pst4), .perf_flush_cycles(pfl4)
`endif
    );

    typedef struct {
        int         kind;
        logic [4:0] rs1, rs2, rd;
        logic       done;
        logic [4:0] drd;
        logic       redir;
        logic       stall, fid, fex;
        logic [2:0] pend;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, int a, int b, int d,
                                bit dn, int dr, bit rd_x,
                                bit st, bit fi, bit fe, int pe,
                                string nm);
        vec_t v;
        v.kind = k; v.rs1 = 5'(a); v.rs2 = 5'(b); v.rd = 5'(d);
        v.done = dn; v.drd = 5'(dr); v.redir = rd_x;
        v.stall = st; v.fid = fi; v.fex = fe; v.pend = 3'(pe);
        v.name = nm;
        return v;
    endfunction

    task automatic drive(int k, int a, int b, int d,
                         bit dn, int dr, bit rd_x, bit r);
        rst         = r;
        id_valid    = (k != K_IDLE);
        id_rs1      = 5'(a);
        id_rs2      = 5'(b);
        id_rd       = 5'(d);
        id_rs1_used = (k != K_IDLE);
        id_rs2_used = (k == K_ALU) || (k == K_MDU);
        id_rd_we    = (k != K_IDLE);
        id_is_load  = (k == K_LD);
        id_is_mdu   = (k == K_MDU);
        mdu_done    = dn;
        mdu_done_rd = 5'(dr);
        ex_redirect = rd_x;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(int k, int a, int b, int d,
                       bit dn, int dr, bit rd_x, bit r);
        @(negedge clk);
        drive(k, a, b, d, dn, dr, rd_x, r);
        #1;
    endtask

    task automatic do_reset();
        cyc(K_IDLE, 0, 0, 0, 0, 0, 0, 1);
        cyc(K_IDLE, 0, 0, 0, 0, 0, 0, 1);
        cyc(K_IDLE, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // MDU raw + bypass release
        vecs.push_back(mk(K_IDLE,0,0,0, 0,0,0, 0,0,0,0,"idle"));
        vecs.push_back(mk(K_MDU, 2,3,5, 0,0,0, 0,0,0,0,"mdu5"));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(K_ALU,5,0,9, 0,0,0, 1,0,1,1,"raw5"));
        vecs.push_back(mk(K_ALU, 5,0,9, 1,5,0, 0,0,0,1,"byp5"));
        vecs.push_back(mk(K_IDLE,0,0,0, 0,0,0, 0,0,0,0,"idle2"));
        // MDU full
        vecs.push_back(mk(K_MDU, 2,3,6, 0,0,0, 0,0,0,0,"mdu6"));
        vecs.push_back(mk(K_MDU, 2,3,7, 0,0,0, 0,0,0,1,"mdu7"));
        vecs.push_back(mk(K_MDU, 1,2,10,0,0,0, 1,0,1,2,"full"));
        vecs.push_back(mk(K_MDU, 1,2,10,0,0,0, 1,0,1,2,"full2"));
        vecs.push_back(mk(K_MDU, 1,2,10,1,6,0, 0,0,0,2,"fulldn"));
        vecs.push_back(mk(K_IDLE,0,0,0, 0,0,0, 0,0,0,2,"pend2"));
        // WAW and x0
        vecs.push_back(mk(K_LD,  2,0,7, 0,0,0, 1,0,1,2,"waw7"));
        vecs.push_back(mk(K_LD,  3,0,0, 0,0,0, 0,0,0,2,"ldx0"));
        vecs.push_back(mk(K_ALU, 0,0,11,0,0,0, 0,0,0,2,"rsx0"));
        // Redirect priority
        vecs.push_back(mk(K_ALU, 10,0,11,0,0,0, 1,0,1,2,"raw10"));
        vecs.push_back(mk(K_ALU, 10,0,11,0,0,1, 0,1,1,2,"redir"));
        vecs.push_back(mk(K_MDU, 2,3,12,0,0,1, 0,1,1,2,"redirm"));
        vecs.push_back(mk(K_IDLE,0,0,0, 0,0,0, 0,0,0,2,"noupd"));
        vecs.push_back(mk(K_ALU, 10,0,11,0,0,0, 1,0,1,2,"still10"));
        vecs.push_back(mk(K_ALU, 7,10,11,1,7,0, 1,0,1,2,"rs2busy"));
        vecs.push_back(mk(K_ALU, 7,0,11,0,0,0, 0,0,0,1,"clr7"));
        vecs.push_back(mk(K_ALU, 10,0,11,1,10,0, 0,0,0,1,"byp10"));
        vecs.push_back(mk(K_IDLE,0,0,0, 0,0,0, 0,0,0,0,"empty"));
        // Load under redirect is not tracked
        vecs.push_back(mk(K_LD,  2,0,13,0,0,1, 0,1,1,0,"ldredir"));
        vecs.push_back(mk(K_ALU, 13,0,11,0,0,0, 0,0,0,0,"nold13"));
        // Load -> MDU WAW
        vecs.push_back(mk(K_LD,  2,0,14,0,0,0, 0,0,0,0,"ld14"));
        vecs.push_back(mk(K_MDU, 2,3,14,0,0,0, 1,0,1,0,"waw14"));
        vecs.push_back(mk(K_MDU, 2,3,14,0,0,0, 0,0,0,0,"mdu14"));
        vecs.push_back(mk(K_IDLE,0,0,0, 0,0,0, 0,0,0,1,"pend1"));

        drive(K_IDLE, 0, 0, 0, 0, 0, 0, 1);

        // Load latency, LOAD_LAT 2 vs 4
        do_reset();
        chk("rst_stall", {30'd0, stall_id, s4_id}, 0);
        chk("rst_pend", {29'd0, mdu_pending}, 0);
        cyc(K_LD, 2, 0, 1, 0, 0, 0, 0);
        chk("ld_t", {30'd0, stall_id, s4_id}, 0);
        cyc(K_ALU, 1, 3, 4, 0, 0, 0, 0);
        chk("ld_t1", {28'd0, stall_if, flush_ex, s4_if, f4_ex}, 4'hf);
        cyc(K_ALU, 1, 3, 4, 0, 0, 0, 0);
        chk("ld_t2", {30'd0, stall_id, s4_id}, 2'b01);
        cyc(K_ALU, 1, 3, 4, 0, 0, 0, 0);
        chk("ld_t3", {30'd0, stall_id, s4_id}, 2'b01);
        cyc(K_ALU, 1, 3, 4, 0, 0, 0, 0);
        chk("ld_t4", {30'd0, stall_id, s4_id}, 2'b00);

        // Table
        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].kind, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].done, vecs[i].drd, vecs[i].redir, 0);
            #1;
            chk({vecs[i].name, ".stall_if"}, 32'(stall_if), 32'(vecs[i].stall));
            chk({vecs[i].name, ".stall_id"}, 32'(stall_id), 32'(vecs[i].stall));
            chk({vecs[i].name, ".flush_id"}, 32'(flush_id), 32'(vecs[i].fid));
            chk({vecs[i].name, ".flush_ex"}, 32'(flush_ex), 32'(vecs[i].fex));
            chk({vecs[i].name, ".pending"}, 32'(mdu_pending), 32'(vecs[i].pend));
        end

        // Reset mid-operation
        do_reset();
        cyc(K_MDU, 2, 3, 14, 0, 0, 0, 0);
        cyc(K_LD, 2, 0, 15, 0, 0, 0, 0);
        chk("pre_rst_pend", {29'd0, mdu_pending}, 1);
        cyc(K_ALU, 15, 14, 11, 0, 0, 0, 1);
        cyc(K_ALU, 15, 14, 11, 0, 0, 0, 0);
        chk("post_rst_stall", {30'd0, stall_id, s4_id}, 0);
        chk("post_rst_pend", {26'd0, mdu_pending, p4}, 0);
`ifdef HAZARD_PERF_EN
        chk("perf_stall", pst, 0);
        chk("perf_flush", pfl, 0);
        chk("perf4_stall", pst4, 0);
`endif
        cyc(K_IDLE, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
